i2c_bus_filter: RTL and testbench

Input conditioner between the raw SCL/SDA pads (uio_in[0], uio_in[1]) and the I2C slave.
- Synchronises both lines into the system clock domain and rejects glitches shorter than a programmable number of cycles.
- Detects START and STOP conditions and tracks bus-busy state.
- Flags a stuck bus.
- Filtered SCL/SDA replace the raw pad signals at the slave inputs; glitch-free registered SCL is required because the slave and register map use SCL as their clock.

---
 rtl/i2c_bus_filter.sv | 147 ++++++++++++++
 tb/tb_i2c_bus_filter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_filter.sv
// I2C pad conditioner: synchronises and deglitches SCL/SDA, then derives edge
// pulses, START/STOP detection, a bus-busy flag and a stuck-bus timeout.
module i2c_bus_filter #(
    parameter int          FILTER_LEN = 4,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_out,
    output logic sda_out,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic bus_timeout
);

    localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [15:0] TO_LAST   = TIMEOUT - 16'd1;
    localparam logic        TO_EN     = (TIMEOUT != 16'd0);

    logic        scl_s1_r, scl_s2_r, sda_s1_r, sda_s2_r;
    logic        scl_filt_r, sda_filt_r, scl_d_r, sda_d_r;
    logic [3:0]  scl_cnt_r, sda_cnt_r;
    logic        busy_r;
    logic [15:0] tcnt_r;

    logic        scl_filt_nxt_s, sda_filt_nxt_s;
    logic [3:0]  scl_cnt_nxt_s, sda_cnt_nxt_s;
    logic        start_nxt_s, stop_nxt_s, timeout_s;
    logic        busy_nxt_s;
    logic [15:0] tcnt_nxt_s;

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_r <= 1'b1;
            scl_s2_r <= 1'b1;
            sda_s1_r <= 1'b1;
            sda_s2_r <= 1'b1;
        end else begin
            scl_s1_r <= scl_in;
            scl_s2_r <= scl_s1_r;
            sda_s1_r <= sda_in;
            sda_s2_r <= sda_s1_r;
        end
    end

    // SCL filter: a bounce back to the held level restarts the count.
    always_comb begin
        scl_filt_nxt_s = scl_filt_r;
        scl_cnt_nxt_s  = 4'd0;
        if (scl_s2_r == scl_filt_r) begin
            scl_cnt_nxt_s = 4'd0;
        end else if (scl_cnt_r == FILT_LAST) begin
            scl_filt_nxt_s = scl_s2_r;
            scl_cnt_nxt_s  = 4'd0;
        end else begin
            scl_cnt_nxt_s = scl_cnt_r + 4'd1;
        end
    end

    // SDA filter, same rule as SCL.
    always_comb begin
        sda_filt_nxt_s = sda_filt_r;
        sda_cnt_nxt_s  = 4'd0;
        if (sda_s2_r == sda_filt_r) begin
            sda_cnt_nxt_s = 4'd0;
        end else if (sda_cnt_r == FILT_LAST) begin
            sda_filt_nxt_s = sda_s2_r;
            sda_cnt_nxt_s  = 4'd0;
        end else begin
            sda_cnt_nxt_s = sda_cnt_r + 4'd1;
        end
    end

    // Filtered lines, their counters and one-cycle delayed copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
            scl_cnt_r  <= 4'd0;
            sda_cnt_r  <= 4'd0;
        end else begin
            scl_filt_r <= scl_filt_nxt_s;
            sda_filt_r <= sda_filt_nxt_s;
            scl_d_r    <= scl_filt_r;
            sda_d_r    <= sda_filt_r;
            scl_cnt_r  <= scl_cnt_nxt_s;
            sda_cnt_r  <= sda_cnt_nxt_s;
        end
    end

    assign scl_out   = scl_filt_r;
    assign sda_out   = sda_filt_r;
    assign scl_rise  = scl_filt_r & ~scl_d_r;
    assign scl_fall  = ~scl_filt_r & scl_d_r;
    assign start_det = scl_filt_r & scl_d_r & ~sda_filt_r & sda_d_r;
    assign stop_det  = scl_filt_r & scl_d_r & sda_filt_r & ~sda_d_r;

    // Look-ahead START/STOP so bus_busy changes in the same cycle as the pulse.
    assign start_nxt_s = scl_filt_nxt_s & scl_filt_r & ~sda_filt_nxt_s & sda_filt_r;
    assign stop_nxt_s  = scl_filt_nxt_s & scl_filt_r & sda_filt_nxt_s & ~sda_filt_r;

    assign timeout_s = TO_EN & busy_r & (tcnt_r == TO_LAST)
                     & ~scl_rise & ~scl_fall & ~start_det;

    // Busy flag and stuck-bus counter next state.
    always_comb begin
        busy_nxt_s = busy_r;
        tcnt_nxt_s = tcnt_r;
        if (start_nxt_s) begin
            busy_nxt_s = 1'b1;
        end else if (stop_nxt_s || timeout_s) begin
            busy_nxt_s = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (!busy_r || scl_rise || scl_fall || start_det || timeout_s) begin
            tcnt_nxt_s = 16'd0;
        end else if (tcnt_r != 16'hFFFF) begin
            tcnt_nxt_s = tcnt_r + 16'd1;
        end else begin
            tcnt_nxt_s = tcnt_r;
        end
    end

    // Busy flag and timeout counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            tcnt_r <= 16'd0;
        end else begin
            busy_r <= busy_nxt_s;
            tcnt_r <= tcnt_nxt_s;
        end
    end

    assign bus_busy    = busy_r;
    assign bus_timeout = timeout_s;

endmodule

// File: tb/tb_i2c_bus_filter.sv
// Directed bench for i2c_bus_filter: two instances share the pads, one with
// TIMEOUT=100 and one with timeout disabled.
module tb_i2c_bus_filter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_in = 1'b1;
    logic sda_in = 1'b1;

    logic a_scl_out, a_sda_out, a_scl_rise, a_scl_fall;
    logic a_start, a_stop, a_busy, a_to;
    logic b_scl_out, b_sda_out, b_scl_rise, b_scl_fall;
    logic b_start, b_stop, b_busy, b_to;

    int checks = 0;
    int errors = 0;
    int rise_n = 0, fall_n = 0, start_n = 0, stop_n = 0, b_to_n = 0;
    int gap_n = 0;
    bit track_gap = 1'b0;

    always #5 clk = ~clk;

    i2c_bus_filter #(.FILTER_LEN(4), .TIMEOUT(16'd100)) dut_a (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
        .scl_out(a_scl_out), .sda_out(a_sda_out),
        .scl_rise(a_scl_rise), .scl_fall(a_scl_fall),
        .start_det(a_start), .stop_det(a_stop),
        .bus_busy(a_busy), .bus_timeout(a_to)
    );

    i2c_bus_filter #(.FILTER_LEN(4), .TIMEOUT(16'd0)) dut_b (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
        .scl_out(b_scl_out), .sda_out(b_sda_out),
        .scl_rise(b_scl_rise), .scl_fall(b_scl_fall),
        .start_det(b_start), .stop_det(b_stop),
        .bus_busy(b_busy), .bus_timeout(b_to)
    );

    function automatic logic [7:0] a_vec();
        return {a_scl_out, a_sda_out, a_scl_rise, a_scl_fall,
                a_start, a_stop, a_busy, a_to};
    endfunction

    function automatic logic [7:0] b_vec();
        return {b_scl_out, b_sda_out, b_scl_rise, b_scl_fall,
                b_start, b_stop, b_busy, b_to};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge and tally pulses.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (a_scl_rise) rise_n++;
            if (a_scl_fall) fall_n++;
            if (a_start) start_n++;
            if (a_stop) begin
                stop_n++;
                track_gap = 1'b0;
            end
            if (b_to) b_to_n++;
            if (track_gap && !a_busy) gap_n++;
        end
    endtask

    task automatic clear_counts();
        rise_n = 0; fall_n = 0; start_n = 0; stop_n = 0; gap_n = 0;
    endtask

    initial begin
        // 1. reset and idle
        step(3);
        check("reset_a", 32'(a_vec()), 32'h0000_00C0);
        check("reset_b", 32'(b_vec()), 32'h0000_00C0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            check("idle_a", 32'(a_vec()), 32'h0000_00C0);
        end
        check("idle_b", 32'(b_vec()), 32'h0000_00C0);

        // 2. 3-cycle SDA glitch rejected, 4-cycle low accepted
        clear_counts();
        sda_in = 1'b0;
        step(3);
        sda_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            check("glitch3_sda", 32'(a_sda_out), 32'd1);
        end
        check("glitch3_nostart", 32'(start_n), 32'd0);
        sda_in = 1'b0;
        step(5);
        check("sda_before_latency", 32'(a_vec()), 32'h0000_00C0);
        step(1);
        check("start_edge_a", 32'(a_vec()), 32'h0000_008A);
        check("start_edge_b", 32'(b_vec()), 32'h0000_008A);
        step(1);
        check("after_start", 32'(a_vec()), 32'h0000_0082);

        // 3. byte of 9 SCL pulses then STOP
        step(10);
        clear_counts();
        track_gap = 1'b1;
        for (int i = 0; i < 9; i++) begin
            scl_in = 1'b0; step(20);
            scl_in = 1'b1; step(20);
        end
        check("byte_busy_mid", 32'(a_busy), 32'd1);
        sda_in = 1'b1;
        step(20);
        check("byte_rise", 32'(rise_n), 32'd9);
        check("byte_fall", 32'(fall_n), 32'd9);
        check("byte_start", 32'(start_n), 32'd0);
        check("byte_stop", 32'(stop_n), 32'd1);
        check("byte_gap", 32'(gap_n), 32'd0);
        check("byte_end_idle", 32'(a_vec()), 32'h0000_00C0);

        // 3b. repeated START with busy unbroken
        clear_counts();
        sda_in = 1'b0; step(20);
        track_gap = 1'b1;
        scl_in = 1'b0; step(20);
        sda_in = 1'b1; step(20);
        scl_in = 1'b1; step(20);
        sda_in = 1'b0; step(20);
        check("rstart_count", 32'(start_n), 32'd2);
        check("rstart_gap", 32'(gap_n), 32'd0);
        scl_in = 1'b0; step(20);
        scl_in = 1'b1; step(20);
        sda_in = 1'b1; step(20);
        check("rstart_stop", 32'(stop_n), 32'd1);
        check("rstart_idle", 32'(a_vec()), 32'h0000_00C0);

        // 4. both lines fall together: SCL edge only
        clear_counts();
        scl_in = 1'b0; sda_in = 1'b0;
        step(6);
        check("both_fall", 32'(a_vec()), 32'h0000_0010);
        scl_in = 1'b1; sda_in = 1'b1;
        step(6);
        check("both_rise", 32'(a_vec()), 32'h0000_00E0);
        check("both_nocond", 32'(start_n + stop_n), 32'd0);

        // 5. START then SCL stuck low
        step(5);
        b_to_n = 0;
        sda_in = 1'b0; step(6);
        check("to_start", 32'(a_vec()), 32'h0000_008A);
        step(10);
        scl_in = 1'b0; step(6);
        check("to_last_edge", 32'(a_vec()), 32'h0000_0012);
        step(99);
        check("to_not_yet", 32'(a_vec()), 32'h0000_0002);
        step(1);
        check("to_fire", 32'(a_vec()), 32'h0000_0003);
        step(1);
        check("to_busy_drop", 32'(a_vec()), 32'h0000_0000);
        check("to_b_busy", 32'(b_busy), 32'd1);
        step(50);
        check("to_b_never", 32'(b_to_n), 32'd0);
        scl_in = 1'b1; step(20);
        sda_in = 1'b1; step(6);
        check("stop_idle_a", 32'(a_vec()), 32'h0000_00C4);
        check("stop_clears_b", 32'(b_vec()), 32'h0000_00C4);
        step(1);

        // 6. asynchronous reset while busy with SDA low
        sda_in = 1'b0; step(16);
        check("pre_rst", 32'(a_vec()), 32'h0000_0082);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_a", 32'(a_vec()), 32'h0000_00C0);
        check("async_rst_b", 32'(b_vec()), 32'h0000_00C0);
        sda_in = 1'b1;
        step(3);
        rst = 1'b0;
        clear_counts();
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("post_rst", 32'(a_vec()), 32'h0000_00C0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
